// File: rtl/lvdt_phase_cal_ctrl.sv
// Owns the LVDT demod phase: manual write-through, or a calibration sweep that keeps the phase with the largest mean |sample|.
// Writes land on the next edge and readdata is combinational; samples are consumed on arrival, never stalled or buffered.
module lvdt_phase_cal_ctrl #(
  parameter int SAMPLE_W   = 16,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_N   = 4,
  parameter int PHASE_STEP = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic [7:0]          phase_out,
  output logic                busy,
  output logic                irq
);
  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_N - 1);
  localparam logic [CNT_W-1:0]    ACCUM_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_CMP, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_phase;
  logic [7:0]        r_manual;
  logic [7:0]        r_cand;
  logic [7:0]        r_best_phase;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_best_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic              r_irq;

  logic              w_wr;
  logic              w_manual_wr;
  logic              w_ctrl_wr;
  logic              w_start;
  logic              w_abort;
  logic              w_irq_clr;
  logic              w_settle_last;
  logic              w_accum_last;
  logic [8:0]        w_cand_sum;
  logic              w_wrap;
  logic [SAMPLE_W-1:0] w_neg;
  logic [SAMPLE_W-1:0] w_abs;
  logic              w_unused_wdata;

  assign w_wr          = chipselect & ~write_n;
  assign w_manual_wr   = w_wr && (address == 2'd0);
  assign w_ctrl_wr     = w_wr && (address == 2'd1);
  // Abort outranks start so a combined write while idle never launches a sweep.
  assign w_start       = w_ctrl_wr & writedata[0] & ~writedata[2];
  assign w_abort       = w_ctrl_wr & writedata[2];
  assign w_irq_clr     = w_ctrl_wr & writedata[1];
  assign w_settle_last = sample_valid && (r_cnt == SETTLE_LAST);
  assign w_accum_last  = sample_valid && (r_cnt == ACCUM_LAST);
  assign w_cand_sum    = {1'b0, r_cand} + 9'(PHASE_STEP);
  assign w_wrap        = w_cand_sum[8];
  assign w_unused_wdata = ^writedata[7:3];

  assign busy      = (r_state != S_IDLE);
  assign phase_out = r_phase;
  assign irq       = r_irq;

  // The most negative sample has no positive twin, so it clamps to full scale.
  always_comb begin
    w_neg = ~sample + SAMPLE_W'(1);
    if (sample == SAMPLE_MIN)      w_abs = SAMPLE_MAX;
    else if (sample[SAMPLE_W-1])   w_abs = w_neg;
    else                           w_abs = sample;
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      2'd0:    readdata = r_manual;
      2'd1:    readdata = {5'b0, r_done, r_irq, busy};
      2'd2:    readdata = r_best_phase;
      default: readdata = r_best_acc[ACC_W-1 -: 8];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start)       w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_last) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_accum_last)  w_state_nxt = S_CMP;
      S_CMP:    w_state_nxt = w_wrap ? S_FINISH : S_SETTLE;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase      <= '0;
      r_manual     <= '0;
      r_cand       <= '0;
      r_best_phase <= '0;
      r_acc        <= '0;
      r_best_acc   <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_manual_wr) r_manual <= writedata;
      if (w_irq_clr)   r_irq    <= 1'b0;
      if (w_abort && (r_state != S_IDLE)) begin
        r_phase <= r_manual;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_manual_wr) r_phase <= writedata;
            if (w_start) begin
              r_cand       <= '0;
              r_phase      <= '0;
              r_best_acc   <= '0;
              r_best_phase <= '0;
              r_acc        <= '0;
              r_cnt        <= '0;
              r_done       <= 1'b0;
            end
          end
          S_SETTLE: if (sample_valid) r_cnt <= w_settle_last ? '0 : r_cnt + CNT_W'(1);
          S_ACCUM: if (sample_valid) begin
            r_acc <= r_acc + ACC_W'(w_abs);
            r_cnt <= w_accum_last ? '0 : r_cnt + CNT_W'(1);
          end
          S_CMP: begin
            if (r_acc > r_best_acc) begin
              r_best_acc   <= r_acc;
              r_best_phase <= r_cand;
            end
            if (!w_wrap) begin
              r_cand  <= w_cand_sum[7:0];
              r_phase <= w_cand_sum[7:0];
              r_acc   <= '0;
              r_cnt   <= '0;
            end
          end
          S_FINISH: begin
            // Placed after the irq_clr and manual-write updates so the sweep result wins.
            r_phase  <= r_best_phase;
            r_manual <= r_best_phase;
            r_done   <= 1'b1;
            r_irq    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lvdt_phase_cal_ctrl.sv
// Scoreboard bench for lvdt_phase_cal_ctrl: a phase-dependent demod model feeds samples, a sweep model predicts the winner.
module tb_lvdt_phase_cal_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic [15:0] sample = 16'h0000;
  logic        sample_valid = 1'b0;
  logic [7:0]  phase_out;
  logic        busy;
  logic        irq;

  lvdt_phase_cal_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sample(sample), .sample_valid(sample_valid),
    .phase_out(phase_out), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_PHASE = 1, K_BUSY = 2, K_IRQ = 3;
  typedef struct packed { int kind; int exp; } chk_t;

  chk_t  exp_q[$];
  string name_q[$];
  int    done_q[$];
  logic  chk_req = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  // Demod model: peak response at p0, falling 10 counts per phase step away from it.
  int    peak_p0 = 96;
  bit    sat_mode = 1'b0;
  bit    fixed_gap = 1'b1;

  function automatic int mag(input int ph, input int p0);
    int d;
    int v;
    d = (ph > p0) ? ph - p0 : p0 - ph;
    v = 1000 - d * 10;
    return (v < 0) ? 0 : v;
  endfunction

  // Sweep model: mean |sample| per candidate, first strictly-largest wins.
  task automatic model_sweep(input int p0, input bit sat, output int bp, output int avg_hi);
    int best;
    int s;
    best = 0;
    bp = 0;
    for (int c = 0; c < 256; c += 8) begin
      s = sat ? 8 * 32767 : 8 * mag(c, p0);
      if (s > best) begin
        best = s;
        bp = c;
      end
    end
    avg_hi = (best / 8) / 256;
  endtask

  initial begin
    int g;
    int cnt;
    int m;
    g = 4;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (cnt >= g - 1) begin
        sample_valid = 1'b1;
        if (sat_mode) sample = 16'h8000;
        else begin
          m = mag(int'(phase_out), peak_p0);
          sample = ($urandom_range(0, 1) != 0) ? 16'(-m) : 16'(m);
        end
        cnt = 0;
        g = fixed_gap ? 4 : int'($urandom_range(1, 4));
      end else begin
        sample_valid = 1'b0;
        sample = 16'($urandom);
        cnt++;
      end
    end
  end

  initial begin
    chk_t  e;
    string nm;
    int    act;
    forever begin
      @(negedge clk);
      if (chk_req) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: check requested with no expectation queued");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          case (e.kind)
            K_RD:    act = int'({24'b0, readdata});
            K_PHASE: act = int'({24'b0, phase_out});
            K_BUSY:  act = int'({31'b0, busy});
            default: act = int'({31'b0, irq});
          endcase
          vectors++;
          if (act != e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, e.exp);
          end
        end
      end
    end
  end

  // Every fall of busy (finish, abort or reset) must leave the predicted phase on the demod.
  initial begin
    logic prev_busy;
    int   ex;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        vectors++;
        if (done_q.size() == 0) begin
          miscompares++;
          $display("FAIL busy_fall: unexpected end of sweep, phase_out=0x%0h", phase_out);
        end else begin
          ex = done_q.pop_front();
          if (int'({24'b0, phase_out}) != ex) begin
            miscompares++;
            $display("FAIL busy_fall_phase: got 0x%0h, expected 0x%0h", phase_out, ex);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic check(input string nm, input int kind, input int addr, input int exp);
    chk_t e;
    e.kind = kind;
    e.exp  = exp;
    exp_q.push_back(e);
    name_q.push_back(nm);
    address    = 2'(addr);
    chipselect = 1'b1;
    write_n    = 1'b1;
    chk_req    = 1'b1;
    @(posedge clk); #1;
    chk_req    = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input int addr, input int data);
    @(posedge clk); #1;
    address    = 2'(addr);
    writedata  = 8'(data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input string nm, input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'({24'b0, phase_out}) == target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: phase_out=0x%0h, expected 0x%0h within %0d cycles", nm, phase_out, target, budget);
    end
  endtask

  task automatic run_sweep(input string nm, input int p0, input bit sat, input bit fixed);
    int bp;
    int hi;
    peak_p0   = p0;
    sat_mode  = sat;
    fixed_gap = fixed;
    model_sweep(p0, sat, bp, hi);
    done_q.push_back(bp);
    bus_write(1, 1);
    check({nm, "_busy"}, K_BUSY, 0, 1);
    wait_idle({nm, "_timeout"}, 8000);
    check({nm, "_phase_out"}, K_PHASE, 0, bp);
    check({nm, "_best_phase"}, K_RD, 2, bp);
    check({nm, "_best_avg_hi"}, K_RD, 3, hi);
    check({nm, "_manual_follows"}, K_RD, 0, bp);
    check({nm, "_status"}, K_RD, 1, 6);
    check({nm, "_irq"}, K_IRQ, 0, 1);
  endtask

  initial begin
    // Reset with a noisy bus.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      address    = 2'($urandom);
      writedata  = 8'($urandom);
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
    end
    check("rst_phase", K_PHASE, 3, 0);
    check("rst_busy", K_BUSY, 3, 0);
    check("rst_irq", K_IRQ, 3, 0);
    check("rst_best_avg", K_RD, 3, 0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    bus_write(0, 8'h5A);
    check("manual_phase_out", K_PHASE, 0, 8'h5A);
    check("manual_readback", K_RD, 0, 8'h5A);

    run_sweep("sweep96", 96, 1'b0, 1'b1);
    bus_write(1, 2);
    check("irq_clr", K_IRQ, 0, 0);
    check("irq_clr_status", K_RD, 1, 4);

    run_sweep("tie100", 100, 1'b0, 1'b0);
    run_sweep("rand_a", int'($urandom_range(0, 255)), 1'b0, 1'b0);
    run_sweep("rand_b", int'($urandom_range(0, 255)), 1'b0, 1'b0);
    run_sweep("saturate", 0, 1'b1, 1'b0);

    // Abort mid-sweep, with an ignored second start along the way.
    bus_write(1, 2);
    bus_write(0, 8'h20);
    peak_p0   = 96;
    sat_mode  = 1'b0;
    fixed_gap = 1'b1;
    bus_write(1, 1);
    wait_phase("abort_reach16", 16, 1000);
    bus_write(1, 1);
    check("second_start_ignored", K_PHASE, 0, 16);
    wait_phase("abort_reach40", 40, 1000);
    done_q.push_back(8'h20);
    bus_write(1, 4);
    check("abort_busy", K_BUSY, 0, 0);
    check("abort_phase", K_PHASE, 0, 8'h20);
    check("abort_status", K_RD, 1, 0);

    bus_write(1, 5);
    check("abort_start_idle", K_BUSY, 0, 0);

    // Reset in the middle of ACCUM, then a clean sweep.
    peak_p0 = int'($urandom_range(0, 255));
    bus_write(1, 1);
    wait_phase("rst_reach24", 24, 1000);
    repeat (30) @(posedge clk);
    #1;
    done_q.push_back(0);
    reset_n = 1'b0;
    check("midrst_phase", K_PHASE, 0, 0);
    check("midrst_busy", K_BUSY, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_sweep("after_rst", int'($urandom_range(0, 255)), 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    if (done_q.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_end_count: %0d expected busy falls missing, expected 0", done_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: stimulus not complete after 80000 cycles, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end
endmodule
